// File: rtl/wr_fifo.sv
// wr_fifo: write-side circular buffer feeding a PE consumer.
// Producer pushes dataLen-bit words; the consumer sees the head word
// combinationally (first-word fall-through) and pops it with rd.
// restart rewinds the pointers for another pass and leaves storage alone.
module wr_fifo #(
  parameter int addrLen = 5,
  parameter int dataLen = 32,
  parameter int peId    = 0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               wr,
  input  logic [dataLen-1:0] dataIn,
  input  logic               rd,
  input  logic               restart,
  output logic [dataLen-1:0] dataOut,
  output logic               full,
  output logic               empty,
  output logic [addrLen:0]   count,
  output logic               wrAck,
  output logic               overflow,
  output logic               underflow
);

  localparam int DEPTH = 1 << addrLen;

  // peId only tags the instance; reject nonsense values when the design is elaborated.
  if (peId < 0) begin : g_bad_peid
    $error("wr_fifo: peId must be non-negative");
  end

  logic [dataLen-1:0] mem [DEPTH];

  logic [addrLen-1:0] head_q, head_d, tail_q, tail_d;
  logic [addrLen-1:0] head_inc, tail_inc;
  logic               fe_q, fe_d;
  logic [addrLen:0]   cnt_q, cnt_d;
  logic               wrack_q, wrack_d;
  logic               ovf_q, ovf_d;
  logic               udf_q, udf_d;
  logic               ptr_eq, wr_en, rd_en;

  assign ptr_eq   = (head_q == tail_q);
  assign full     = ptr_eq & fe_q;
  assign empty    = ptr_eq & ~fe_q;
  assign head_inc = head_q + addrLen'(1);
  assign tail_inc = tail_q + addrLen'(1);

  // A write while full is still taken when the same cycle pops; a pop while
  // empty is never taken, so an empty FIFO does not bypass wr straight to rd.
  assign wr_en = wr & (~full | rd) & ~restart;
  assign rd_en = rd & ~empty & ~restart;

  assign dataOut   = mem[head_q];
  assign count     = cnt_q;
  assign wrAck     = wrack_q;
  assign overflow  = ovf_q;
  assign underflow = udf_q;

  // Next-state for pointers, full/empty distinguisher, occupancy and status flags.
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    fe_d    = fe_q;
    cnt_d   = cnt_q;
    wrack_d = wr_en;
    ovf_d   = ovf_q | (wr & full & ~rd);
    udf_d   = udf_q | (rd & empty);
    if (wr_en) tail_d = tail_inc;
    if (rd_en) head_d = head_inc;
    // Simultaneous push and pop keep the pointer gap, so the bit holds.
    if (wr_en && !rd_en) begin
      cnt_d = cnt_q + (addrLen+1)'(1);
      if (tail_inc == head_q) fe_d = 1'b1;
    end else if (rd_en && !wr_en) begin
      cnt_d = cnt_q - (addrLen+1)'(1);
      if (head_inc == tail_q) fe_d = 1'b0;
    end
    if (restart) begin
      head_d  = '0;
      tail_d  = '0;
      fe_d    = 1'b0;
      cnt_d   = '0;
      wrack_d = 1'b0;
      ovf_d   = 1'b0;
      udf_d   = 1'b0;
    end
  end

  // Control state register; async active-low clear.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      fe_q    <= 1'b0;
      cnt_q   <= '0;
      wrack_q <= 1'b0;
      ovf_q   <= 1'b0;
      udf_q   <= 1'b0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      fe_q    <= fe_d;
      cnt_q   <= cnt_d;
      wrack_q <= wrack_d;
      ovf_q   <= ovf_d;
      udf_q   <= udf_d;
    end
  end

  // Storage write; contents survive reset and restart.
  always_ff @(posedge clk) begin
    if (wr_en) mem[tail_q] <= dataIn;
  end

endmodule

// File: tb/tb_wr_fifo.sv
// Scoreboard bench for wr_fifo: the driver queues each word it expects the
// FIFO to accept; a negedge monitor pops and compares on every accepted pop.
module tb_wr_fifo;
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        wr = 1'b0, rd = 1'b0, restart = 1'b0;
  logic [31:0] dataIn = '0;
  logic [31:0] dataOut;
  logic        full, empty, wrAck, overflow, underflow;
  logic [5:0]  count;

  int nchk = 0, npass = 0;
  logic [31:0] exp_q [$];

  wr_fifo #(.addrLen(5), .dataLen(32), .peId(0)) dut (
    .clk(clk), .reset(reset), .wr(wr), .dataIn(dataIn), .rd(rd),
    .restart(restart), .dataOut(dataOut), .full(full), .empty(empty),
    .count(count), .wrAck(wrAck), .overflow(overflow), .underflow(underflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act === exp) npass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  // Monitor: an accepted pop must return the oldest queued word.
  always @(negedge clk) begin
    if (reset && rd && !empty && !restart) begin
      if (exp_q.size() == 0) chk("sb_unexpected_pop", dataOut, 32'hFFFF_FFFF);
      else chk("sb_pop_data", dataOut, exp_q.pop_front());
    end
  end

  // One clock with the given inputs; returns 1 time unit after the edge.
  task automatic cyc(input logic w, input logic [31:0] d, input logic r, input logic rs);
    wr = w; dataIn = d; rd = r; restart = rs;
    @(posedge clk); #1;
    wr = 1'b0; rd = 1'b0; restart = 1'b0;
  endtask

  task automatic push(input logic [31:0] d);
    exp_q.push_back(d);
    cyc(1'b1, d, 1'b0, 1'b0);
  endtask

  task automatic pop();
    cyc(1'b0, '0, 1'b1, 1'b0);
  endtask

  initial begin
    // Reset state
    #2;
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_full", 32'(full), 32'd0);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_wrack", 32'(wrAck), 32'd0);
    chk("rst_ovf", 32'(overflow), 32'd0);
    chk("rst_udf", 32'(underflow), 32'd0);
    #10 reset = 1'b1;
    @(posedge clk); #1;

    // Three writes, wrAck follows each, then FWFT drain
    for (int i = 1; i <= 3; i++) begin
      push(32'(i));
      chk("t1_wrack", 32'(wrAck), 32'd1);
    end
    cyc(1'b0, '0, 1'b0, 1'b0);
    chk("t1_wrack_low", 32'(wrAck), 32'd0);
    chk("t1_count", 32'(count), 32'd3);
    chk("t1_empty", 32'(empty), 32'd0);
    chk("t1_head", dataOut, 32'h1);
    for (int i = 0; i < 3; i++) pop();
    chk("t1_empty_end", 32'(empty), 32'd1);
    chk("t1_count_end", 32'(count), 32'd0);

    // Fill to full, rejected write, then push+pop while full
    for (int i = 0; i < 32; i++) push(32'hA000_0000 + 32'(i));
    chk("t2_full", 32'(full), 32'd1);
    chk("t2_count", 32'(count), 32'd32);
    cyc(1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0);
    chk("t2_ovf", 32'(overflow), 32'd1);
    chk("t2_count_ovf", 32'(count), 32'd32);
    chk("t2_wrack_ovf", 32'(wrAck), 32'd0);
    exp_q.push_back(32'hA000_0020);
    cyc(1'b1, 32'hA000_0020, 1'b1, 1'b0);
    chk("t2_head_adv", dataOut, 32'hA000_0001);
    chk("t2_full_rw", 32'(full), 32'd1);
    chk("t2_count_rw", 32'(count), 32'd32);
    for (int i = 0; i < 32; i++) pop();
    chk("t2_empty", 32'(empty), 32'd1);

    // Pointer wrap: from zero, 20 in/out, then 20 more wrapping to 8
    cyc(1'b0, '0, 1'b0, 1'b1);
    chk("t3_ovf_cleared", 32'(overflow), 32'd0);
    for (int i = 0; i < 20; i++) push(32'hC0DE_0000 + 32'(i));
    for (int i = 0; i < 20; i++) pop();
    for (int i = 0; i < 20; i++) push(32'hB0 + 32'(i));
    chk("t3_count", 32'(count), 32'd20);
    chk("t3_head", dataOut, 32'hB0);
    for (int i = 0; i < 20; i++) pop();
    chk("t3_empty", 32'(empty), 32'd1);
    chk("t3_udf_none", 32'(underflow), 32'd0);

    // wr+rd on empty: write only, underflow flagged
    exp_q.push_back(32'h5);
    cyc(1'b1, 32'h5, 1'b1, 1'b0);
    chk("t4_udf", 32'(underflow), 32'd1);
    chk("t4_count", 32'(count), 32'd1);
    chk("t4_data", dataOut, 32'h5);
    pop();
    chk("t4_empty", 32'(empty), 32'd1);

    // restart with a concurrent write: write dropped, storage kept
    cyc(1'b0, '0, 1'b0, 1'b1);
    for (int i = 0; i < 10; i++) push(32'hD0 + 32'(i));
    exp_q.delete();
    cyc(1'b1, 32'hEEEE_EEEE, 1'b0, 1'b1);
    chk("t5_count", 32'(count), 32'd0);
    chk("t5_empty", 32'(empty), 32'd1);
    chk("t5_ovf", 32'(overflow), 32'd0);
    chk("t5_udf", 32'(underflow), 32'd0);
    chk("t5_wrack", 32'(wrAck), 32'd0);
    chk("t5_mem0", dataOut, 32'hD0);

    // Async reset between edges with 7 entries held
    for (int i = 0; i < 7; i++) push(32'hE0 + 32'(i));
    chk("t6_count_pre", 32'(count), 32'd7);
    #2 reset = 1'b0;
    #1;
    chk("t6_empty", 32'(empty), 32'd1);
    chk("t6_count", 32'(count), 32'd0);
    chk("t6_wrack", 32'(wrAck), 32'd0);
    exp_q.delete();
    #3 reset = 1'b1;
    @(posedge clk); #1;
    push(32'hF1);
    chk("t6_entry0", dataOut, 32'hF1);
    chk("t6_count_post", 32'(count), 32'd1);
    pop();
    chk("t6_empty_end", 32'(empty), 32'd1);
    chk("sb_drained", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end
endmodule
